// File: rtl/piano_pkg.sv
// Shared piano constants and voice-state type used by the allocator, the input
// conditioners and the tone generators.
package piano_pkg;

  localparam int unsigned NUM_KEYS   = 8;
  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned KEY_W      = 3;
  localparam int unsigned VOICE_W    = 2;

  typedef enum logic {
    V_FREE   = 1'b0,
    V_ACTIVE = 1'b1
  } voice_state_e;

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit encoder: flags any request and returns its index and onehot.
module prio_pick #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [W-1:0]     req,
  output logic             valid_c,
  output logic [IDX_W-1:0] index_c,
  output logic [W-1:0]     onehot_c
);

  // Scan high to low so the lowest set bit is the final assignment.
  always_comb begin
    valid_c  = 1'b0;
    index_c  = '0;
    onehot_c = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid_c     = 1'b1;
        index_c     = IDX_W'(i);
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: queues key presses, serves one per cycle onto a voice
// (retrigger, free voice, or round-robin steal) and frees voices on release.
module voice_allocator
  import piano_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_rise,
  input  logic [NUM_KEYS-1:0]         key_fall,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic                        steal,
  output logic                        busy
);

  // Registered state
  voice_state_e           vstate   [NUM_VOICES];
  logic [KEY_W-1:0]       vkey     [NUM_VOICES];
  logic [NUM_KEYS-1:0]    pend;
  logic [VOICE_W-1:0]     steal_ptr;

  // Next-state values
  voice_state_e           vstate_n [NUM_VOICES];
  logic [KEY_W-1:0]       vkey_n   [NUM_VOICES];
  logic [NUM_KEYS-1:0]    pend_n;
  logic [VOICE_W-1:0]     steal_ptr_n;
  logic [NUM_VOICES-1:0]  start_n;
  logic                   steal_n;
  logic                   busy_n;

  // Selection signals
  logic [NUM_KEYS-1:0]    cand;
  logic                   kv;
  logic [KEY_W-1:0]       k_idx;
  logic [NUM_KEYS-1:0]    k_oh;
  logic [NUM_VOICES-1:0]  free_vec;
  logic                   fv;
  logic [VOICE_W-1:0]     unused_free_idx;
  logic [NUM_VOICES-1:0]  f_oh;
  logic [NUM_VOICES-1:0]  hit_oh;
  logic [NUM_VOICES-1:0]  steal_oh;
  logic [NUM_VOICES-1:0]  alloc_oh;
  logic                   hit_any;

  // A fall on the same cycle cancels a pending press before it can be served.
  assign cand = pend & ~key_fall;

  prio_pick #(.W(NUM_KEYS), .IDX_W(KEY_W)) u_key_pick (
    .req      (cand),
    .valid_c  (kv),
    .index_c  (k_idx),
    .onehot_c (k_oh)
  );

  prio_pick #(.W(NUM_VOICES), .IDX_W(VOICE_W)) u_voice_pick (
    .req      (free_vec),
    .valid_c  (fv),
    .index_c  (unused_free_idx),
    .onehot_c (f_oh)
  );

  // Output decode of registered voice state; free vector feeds the picker.
  always_comb begin
    voice_active = '0;
    voice_key    = '0;
    free_vec     = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      voice_active[v]              = (vstate[v] == V_ACTIVE);
      voice_key[v*KEY_W +: KEY_W]  = vkey[v];
      free_vec[v]                  = (vstate[v] == V_FREE);
    end
  end

  // Choose the target voice: existing holder, else lowest free, else steal_ptr.
  always_comb begin
    hit_oh   = '0;
    steal_oh = '0;
    alloc_oh = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      hit_oh[v]   = (vstate[v] == V_ACTIVE) && (vkey[v] == k_idx);
      steal_oh[v] = (steal_ptr == VOICE_W'(v));
    end
    hit_any = |hit_oh;
    if (kv) begin
      if (hit_any)  alloc_oh = hit_oh;
      else if (fv)  alloc_oh = f_oh;
      else          alloc_oh = steal_oh;
    end
  end

  // Next-state: pending update, releases, then allocation overriding release.
  always_comb begin
    vstate_n    = vstate;
    vkey_n      = vkey;
    start_n     = '0;
    steal_n     = 1'b0;
    steal_ptr_n = steal_ptr;
    pend_n      = (pend | key_rise) & ~key_fall & ~(kv ? k_oh : '0);
    busy_n      = |pend_n;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if ((vstate[v] == V_ACTIVE) && key_fall[vkey[v]]) begin
        vstate_n[v] = V_FREE;
        vkey_n[v]   = '0;
      end
      if (alloc_oh[v]) begin
        vstate_n[v] = V_ACTIVE;
        vkey_n[v]   = k_idx;
        start_n[v]  = 1'b1;
      end
    end
    if (kv && !hit_any && !fv) begin
      steal_n     = 1'b1;
      steal_ptr_n = (steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0
                                                           : steal_ptr + VOICE_W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        vstate[v] <= V_FREE;
        vkey[v]   <= '0;
      end
      pend        <= '0;
      steal_ptr   <= '0;
      voice_start <= '0;
      steal       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vstate      <= vstate_n;
      vkey        <= vkey_n;
      pend        <= pend_n;
      steal_ptr   <= steal_ptr_n;
      voice_start <= start_n;
      steal       <= steal_n;
      busy        <= busy_n;
    end
  end

endmodule
